// File: rtl/instr_loader_pkg.sv
// Shared widths, FSM encodings and the buffered fetch entry type for the instruction loader.
package instr_loader_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t REQ  = 2'd1;
  localparam state_t WAIT = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] data;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous DEPTH-entry FIFO of fetch entries; push visible at head one cycle later.
// clear drops all contents and overrides a same-cycle push/pop; head reads as zero when empty.
module instr_fifo
  import instr_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       head_valid,
  output fetch_entry_t               head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t       mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign head_valid = (count != '0);
  assign push_ok    = push & (count != DEPTH_C);
  assign pop_ok     = pop & head_valid;
  assign head       = head_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok && !rst && !clear) begin
      mem[wr_ptr] <= push_entry;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Fetch stage: takes translated PCs, issues one memory read per PC, queues {pc, insn, fault} in order.
// PC ready only when idle with a free FIFO slot; flush empties the queue and discards in-flight work.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_valid,
  output logic            pc_ready,
  input  logic [XLEN-1:0] pc_addr,
  input  logic            pc_fault,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [ILEN-1:0] mem_rsp_data,
  input  logic            mem_rsp_err,
  output logic            ins_valid,
  input  logic            ins_ready,
  output logic [XLEN-1:0] ins_pc,
  output logic [ILEN-1:0] ins_data,
  output logic            ins_fault,
  input  logic            flush,
  output logic            busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t          state;
  logic            kill;
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   count;
  logic            pc_fire;
  logic            push;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign pc_ready      = (state == IDLE) & ~kill & (count < DEPTH_C) & ~flush & ~rst;
  assign pc_fire       = pc_valid & pc_ready;
  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = pc_q;
  assign busy          = (state != IDLE) | kill;

  assign ins_pc    = head.pc;
  assign ins_data  = head.data;
  assign ins_fault = head.fault;

  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (pc_fire && pc_fault) begin
      push             = 1'b1;
      push_entry.pc    = pc_addr;
      push_entry.fault = 1'b1;
    end else if (state == WAIT && mem_rsp_valid && !kill) begin
      push             = 1'b1;
      push_entry.pc    = pc_q;
      push_entry.data  = mem_rsp_data;
      push_entry.fault = mem_rsp_err;
    end
  end

  // A killed request is still carried to completion so the memory never sees a withdrawn valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      kill  <= 1'b0;
      pc_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_fire && !pc_fault) begin
            pc_q  <= pc_addr;
            state <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) state <= WAIT;
          if (flush)         kill  <= 1'b1;
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            state <= IDLE;
            kill  <= 1'b0;
          end else if (flush) begin
            kill <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          kill  <= 1'b0;
        end
      endcase
    end
  end

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clear      (flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (ins_ready),
    .count      (count),
    .head_valid (ins_valid),
    .head       (head)
  );

endmodule

// File: tb/tb_instr_loader.sv
// Directed-vector bench for instr_loader with hand-computed expectations.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid;
  logic        pc_ready;
  logic [31:0] pc_addr;
  logic        pc_fault;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_pc;
  logic [31:0] ins_data;
  logic        ins_fault;
  logic        flush;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  instr_loader #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_valid      (pc_valid),
    .pc_ready      (pc_ready),
    .pc_addr       (pc_addr),
    .pc_fault      (pc_fault),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err),
    .ins_valid     (ins_valid),
    .ins_ready     (ins_ready),
    .ins_pc        (ins_pc),
    .ins_data      (ins_data),
    .ins_fault     (ins_fault),
    .flush         (flush),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full fetch against a zero-wait memory; returns in the cycle after the response edge.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input logic e);
    int n;
    pc_valid = 1'b1;
    pc_addr  = a;
    pc_fault = 1'b0;
    n = 0;
    while (!pc_ready && n < 20) begin
      tick();
      n++;
    end
    check("fetch_pc_ready", pc_ready, 1);
    tick();
    pc_valid      = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    mem_rsp_err   = e;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] exp_dat;

    rst = 1'b1; pc_valid = 1'b0; pc_addr = '0; pc_fault = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
    ins_ready = 1'b0; flush = 1'b0;
    repeat (3) tick();

    check("rst_pc_ready",  pc_ready, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_ins_valid", ins_valid, 0);
    check("rst_busy",      busy, 0);
    check("rst_ins_pc",    ins_pc, 0);
    check("rst_ins_data",  ins_data, 0);
    check("rst_ins_fault", ins_fault, 0);
    rst = 1'b0;
    tick();

    // Basic fetch of 0x1000, response two cycles after acceptance.
    pc_valid = 1'b1; pc_addr = 32'h1000;
    check("t1_pc_ready", pc_ready, 1);
    tick();
    pc_valid = 1'b0;
    check("t1_req_valid", mem_req_valid, 1);
    check("t1_req_addr",  mem_req_addr, 32'h1000);
    check("t1_busy",      busy, 1);
    check("t1_pc_ready_req", pc_ready, 0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("t1_req_drop", mem_req_valid, 0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0013;
    check("t1_no_bypass", ins_valid, 0);
    tick();
    mem_rsp_valid = 1'b0;
    check("t1_ins_valid", ins_valid, 1);
    check("t1_ins_pc",    ins_pc, 32'h1000);
    check("t1_ins_data",  ins_data, 32'h13);
    check("t1_ins_fault", ins_fault, 0);
    check("t1_pc_ready_back", pc_ready, 1);
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    check("t1_popped", ins_valid, 0);

    // Translation fault: entry next cycle, no memory access.
    pc_valid = 1'b1; pc_addr = 32'h2000; pc_fault = 1'b1;
    tick();
    pc_valid = 1'b0; pc_fault = 1'b0;
    check("t2_ins_valid", ins_valid, 1);
    check("t2_ins_pc",    ins_pc, 32'h2000);
    check("t2_ins_data",  ins_data, 0);
    check("t2_ins_fault", ins_fault, 1);
    check("t2_no_req",    mem_req_valid, 0);
    check("t2_busy",      busy, 0);
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;

    // Fill the FIFO without popping; order must be preserved.
    for (int i = 0; i < 4; i++) begin
      do_fetch(32'(i * 4), 32'h0A00_0000 + 32'(i * 4), 1'b0);
    end
    pc_valid = 1'b1; pc_addr = 32'h10;
    check("t3_full_pc_ready", pc_ready, 0);
    check("t3_head_pc",       ins_pc, 32'h0);
    check("t3_head_data",     ins_data, 32'h0A00_0000);
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0; pc_valid = 1'b0;
    check("t3_pc_ready_after_pop", pc_ready, 1);
    for (int i = 1; i < 4; i++) begin
      exp_pc  = 32'(i * 4);
      exp_dat = 32'h0A00_0000 + 32'(i * 4);
      check("t3_order_valid", ins_valid, 1);
      check("t3_order_pc",    ins_pc, exp_pc);
      check("t3_order_data",  ins_data, exp_dat);
      ins_ready = 1'b1;
      tick();
      ins_ready = 1'b0;
    end
    check("t3_empty", ins_valid, 0);

    // Flush in WAIT: buffered entry dropped, late response discarded.
    pc_valid = 1'b1; pc_addr = 32'h3C; pc_fault = 1'b1;
    tick();
    pc_valid = 1'b0; pc_fault = 1'b0;
    check("t4_pre_entry", ins_valid, 1);
    pc_valid = 1'b1; pc_addr = 32'h40;
    tick();
    pc_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    flush = 1'b1;
    check("t4_flush_pc_ready", pc_ready, 0);
    tick();
    flush = 1'b0;
    check("t4_flushed_valid", ins_valid, 0);
    check("t4_busy_kill",     busy, 1);
    check("t4_pc_ready_kill", pc_ready, 0);
    tick();
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
    check("t4_busy_at_rsp", busy, 1);
    tick();
    mem_rsp_valid = 1'b0;
    check("t4_dropped",     ins_valid, 0);
    check("t4_pc_ready_on", pc_ready, 1);
    check("t4_busy_off",    busy, 0);

    // Stalled request held stable; flush mid-stall kills the response.
    pc_valid = 1'b1; pc_addr = 32'h60;
    tick();
    pc_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t5_req_held",  mem_req_valid, 1);
      check("t5_addr_held", mem_req_addr, 32'h60);
      flush = (i == 1);
      tick();
    end
    flush = 1'b0;
    check("t5_req_still", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("t5_wait_pc_ready", pc_ready, 0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
    tick();
    mem_rsp_valid = 1'b0;
    check("t5_dropped",  ins_valid, 0);
    check("t5_pc_ready", pc_ready, 1);

    // Stray response while idle is ignored.
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h55;
    tick();
    mem_rsp_valid = 1'b0;
    check("stray_ignored", ins_valid, 0);

    // Bus error response, then reset mid-WAIT.
    do_fetch(32'h80, 32'hCAFE_F00D, 1'b1);
    check("t6_ins_valid", ins_valid, 1);
    check("t6_ins_pc",    ins_pc, 32'h80);
    check("t6_ins_data",  ins_data, 32'hCAFE_F00D);
    check("t6_ins_fault", ins_fault, 1);
    pc_valid = 1'b1; pc_addr = 32'h84;
    tick();
    pc_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("t6_busy_wait", busy, 1);
    rst = 1'b1;
    tick();
    check("t6_rst_ins_valid", ins_valid, 0);
    check("t6_rst_req_valid", mem_req_valid, 0);
    check("t6_rst_req_addr",  mem_req_addr, 0);
    check("t6_rst_pc_ready",  pc_ready, 0);
    check("t6_rst_busy",      busy, 0);
    check("t6_rst_ins_pc",    ins_pc, 0);
    check("t6_rst_ins_data",  ins_data, 0);
    check("t6_rst_ins_fault", ins_fault, 0);
    rst = 1'b0;
    tick();
    check("t6_post_rst_ready", pc_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
